// File: rtl/sorted_display_scan_pkg.sv
// Shared constants for the sorted-result display: segment table, blank codes
// and the digit-index to anode mapping.
package sorted_display_scan_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low {g,f,e,d,c,b,a}; entry 15 first so SEG_LUT[v] decodes v.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Digit 0 is the leftmost position so results read ascending left to right.
  localparam logic [3:0][3:0] AN_MAP = {4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic logic [3:0] digit_an(input logic [1:0] idx);
    return AN_MAP[idx];
  endfunction

endpackage

// File: rtl/sorted_display_scan_hex7seg.sv
// Combinational hex digit to active-low 7-segment decoder.
module sorted_display_scan_hex7seg
  import sorted_display_scan_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[hex_i];

endmodule

// File: rtl/sorted_display_scan.sv
// Captures the sorter result on the done edge and time-multiplexes it onto a
// 4-digit common-anode 7-segment display.
module sorted_display_scan
  import sorted_display_scan_pkg::*;
#(
  parameter  int REFRESH_DIV = 50000,
  localparam int CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_display,
  input  logic       freeze,
  input  logic [3:0] sorted_num0,
  input  logic [3:0] sorted_num1,
  input  logic [3:0] sorted_num2,
  input  logic [3:0] sorted_num3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       result_valid
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic             sd_q;
  logic             valid_q,  valid_d;
  logic [3:0][3:0]  held_q,   held_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [1:0]       idx_q,    idx_d;
  logic [3:0]       an_q,     an_d;
  logic [6:0]       seg_q,    seg_d;
  logic             capture;
  logic [3:0]       digit_hex;
  logic [6:0]       digit_seg;

  // sd_q resets high so a sorter already idle at reset is not taken as a new result.
  assign capture   = start_display & ~sd_q & ~freeze;
  assign digit_hex = held_q[idx_q];

  sorted_display_scan_hex7seg u_hex7seg (
    .hex_i (digit_hex),
    .seg_o (digit_seg)
  );

  // Next-state for holding registers, refresh counter, digit index and outputs.
  always_comb begin
    held_d  = held_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    an_d    = AN_OFF;
    seg_d   = SEG_BLANK;

    // A capture restarts the scan at digit 0 even on a terminal count.
    if (capture) begin
      held_d  = {sorted_num3, sorted_num2, sorted_num1, sorted_num0};
      valid_d = 1'b1;
      cnt_d   = {CNT_W{1'b0}};
      idx_d   = 2'd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = {CNT_W{1'b0}};
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (valid_q) begin
      an_d  = digit_an(idx_q);
      seg_d = digit_seg;
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sd_q    <= 1'b1;
      valid_q <= 1'b0;
      held_q  <= {4{4'h0}};
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= 2'd0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
    end else begin
      sd_q    <= start_display;
      valid_q <= valid_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an           = an_q;
  assign seg          = seg_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_sorted_display_scan.sv
// Self-checking bench for sorted_display_scan: directed scenarios plus random
// stimulus against a cycle-count based reference model.
module tb_sorted_display_scan;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_display = 1'b1;
  logic       freeze = 1'b0;
  logic [3:0] sorted_num0 = 4'h0;
  logic [3:0] sorted_num1 = 4'h0;
  logic [3:0] sorted_num2 = 4'h0;
  logic [3:0] sorted_num3 = 4'h0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       result_valid;

  int checks = 0;
  int errors = 0;

  // Reference model: ticks since reset/capture determine the lit digit.
  int         m_t;
  logic       m_sd;
  logic       m_valid;
  logic [3:0] m_held [4];
  logic [3:0] exp_an;
  logic [6:0] exp_seg;

  sorted_display_scan #(.REFRESH_DIV(DIV)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_display (start_display),
    .freeze        (freeze),
    .sorted_num0   (sorted_num0),
    .sorted_num1   (sorted_num1),
    .sorted_num2   (sorted_num2),
    .sorted_num3   (sorted_num3),
    .an            (an),
    .seg           (seg),
    .result_valid  (result_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic int cur_idx();
    return (m_t / DIV) % 4;
  endfunction

  task automatic model_reset();
    m_t = 0; m_sd = 1'b1; m_valid = 1'b0;
    for (int i = 0; i < 4; i++) m_held[i] = 4'h0;
    exp_an = 4'hF; exp_seg = 7'h7F;
  endtask

  // One clock: advance model on the posedge, return at the following negedge.
  task automatic tick();
    int k;
    @(posedge clk);
    k = cur_idx();
    if (m_valid) begin
      exp_an  = 4'b1111 ^ (4'b1000 >> k);
      exp_seg = ref_seg(m_held[k]);
    end else begin
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
    end
    if (start_display === 1'b1 && m_sd === 1'b0 && freeze === 1'b0) begin
      m_held[0] = sorted_num0; m_held[1] = sorted_num1;
      m_held[2] = sorted_num2; m_held[3] = sorted_num3;
      m_valid = 1'b1;
      m_t = 0;
    end else begin
      m_t = (m_t + 1) % (4 * DIV);
    end
    m_sd = start_display;
    @(negedge clk);
  endtask

  task automatic set_nums(input logic [3:0] a, b, c, d);
    sorted_num0 = a; sorted_num1 = b; sorted_num2 = c; sorted_num3 = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_display = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: an=%h seg=%h valid=%b, want an=f seg=7f valid=0", an, seg, result_valid);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || result_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_capture cyc%0d: an=%h seg=%h valid=%b, want blank, valid=0", i, an, seg, result_valid);
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0] seq_an [5];
    logic [6:0] seq_seg [5];
    seq_an  = '{4'h7, 4'hB, 4'hD, 4'hE, 4'h7};
    seq_seg = '{7'h79, 7'h30, 7'h10, 7'h46, 7'h79};
    set_nums(4'h1, 4'h3, 4'h9, 4'hC);
    start_display = 1'b0; tick(); tick();
    start_display = 1'b1; tick();
    checks++;
    if (result_valid !== 1'b1) begin
      errors++;
      $display("FAIL capture_valid: valid=%b, want 1", result_valid);
    end
    for (int d = 0; d < 5; d++) begin
      for (int c = 0; c < DIV; c++) begin
        tick();
        checks++;
        if (an !== seq_an[d] || seg !== seq_seg[d] || an !== exp_an || seg !== exp_seg) begin
          errors++;
          $display("FAIL scan digit%0d cyc%0d: an=%h seg=%h, want an=%h seg=%h", d, c, an, seg, seq_an[d], seq_seg[d]);
        end
      end
    end
  endtask

  task automatic test_freeze();
    start_display = 1'b0; tick();
    freeze = 1'b1; set_nums(4'h0, 4'h0, 4'h0, 4'h0);
    start_display = 1'b1; tick();
    for (int i = 0; i < 3 * 4 * DIV; i++) begin
      if (i == 2) freeze = 1'b0;
      tick();
      checks++;
      if (an !== exp_an || seg !== exp_seg || result_valid !== 1'b1 || seg === 7'h40) begin
        errors++;
        $display("FAIL freeze cyc%0d: an=%h seg=%h valid=%b, want an=%h seg=%h valid=1", i, an, seg, result_valid, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_midscan_recapture();
    int n;
    start_display = 1'b0; tick();
    n = 0;
    while (cur_idx() != 2 && n < 8 * DIV) begin tick(); n++; end
    checks++;
    if (cur_idx() != 2) begin
      errors++;
      $display("FAIL midscan_reach_idx2: idx=%0d, want 2", cur_idx());
    end
    set_nums(4'h5, 4'h6, 4'h7, 4'h8);
    start_display = 1'b1;
    for (int i = 0; i < 5 * DIV; i++) begin
      tick();
      checks++;
      if (an !== exp_an || seg !== exp_seg || (i > 0 && (seg === 7'h79 || seg === 7'h10 || seg === 7'h46))) begin
        errors++;
        $display("FAIL midscan cyc%0d: an=%h seg=%h, want an=%h seg=%h", i, an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_capture_terminal();
    int n;
    int run;
    start_display = 1'b0; tick();
    n = 0;
    while ((m_t % DIV) != DIV - 1 && n < 2 * DIV) begin tick(); n++; end
    set_nums(4'hA, 4'hB, 4'hD, 4'hF);
    start_display = 1'b1; tick();
    run = 0;
    for (int i = 0; i < 3 * DIV; i++) begin
      tick();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL cap_terminal cyc%0d: an=%h seg=%h, want an=%h seg=%h", i, an, seg, exp_an, exp_seg);
      end
      if (an === 4'h7 && run == i) run++;
    end
    checks++;
    if (run != DIV) begin
      errors++;
      $display("FAIL cap_terminal_dwell: digit0 lit %0d cycles, want %0d", run, DIV);
    end
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    while (!(cur_idx() == 3 && m_t % DIV == 1) && n < 8 * DIV) begin tick(); n++; end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: an=%h seg=%h valid=%b, want an=f seg=7f valid=0", an, seg, result_valid);
    end
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || result_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset cyc%0d: an=%h seg=%h valid=%b, want blank", i, an, seg, result_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) start_display = ~start_display;
      freeze = ($urandom_range(0, 4) == 0);
      set_nums(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      tick();
      checks++;
      if (an !== exp_an || seg !== exp_seg || result_valid !== m_valid) begin
        errors++;
        $display("FAIL random cyc%0d: an=%h seg=%h valid=%b, want an=%h seg=%h valid=%b",
                 i, an, seg, result_valid, exp_an, exp_seg, m_valid);
      end
    end
    freeze = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_freeze();
    test_midscan_recapture();
    test_capture_terminal();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sorted_display_scan.md
Name: sorted_display_scan

Overview:
- Consumer end of the sorter's result interface.
- Watches start_display for the done edge, then latches sorted_num0..3.
- Time-multiplexes the held result onto a 4-digit common-anode 7-segment display.
- Sits between the sorting block and the board display pins. Holds the last result until the next sort completes.

Parameters:
REFRESH_DIV, 50000, clk cycles each digit stays lit (min 2)
CNT_W, $clog2(REFRESH_DIV), refresh counter width (derived, not overridden)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start_display  input  1  sorter idle/done level (high when sorter cnt==0)
freeze  input  1  high = ignore new results, keep showing held values
sorted_num0  input  4  smallest sorted value
sorted_num1  input  4  second value
sorted_num2  input  4  third value
sorted_num3  input  4  largest value
an  output  4  digit enables, active-low, an[3] leftmost
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
result_valid  output  1  high once a result has been captured since reset

Behaviour:
- Reset (async, rst=1):
  - held0..3=0, result_valid=0, refresh counter=0, digit idx=0.
  - sd_q=1, an=4'b1111, seg=7'h7F. Applies immediately, including mid-scan.
- Done-edge detect:
  - sd_q registers start_display every cycle.
  - capture = start_display & ~sd_q & ~freeze.
  - sd_q resets to 1, so an idle-high start_display after reset never triggers a capture.
- Capture cycle:
  - held0..3 <= sorted_num0..3, all four together; result_valid <= 1.
  - The same edge also clears the refresh counter and sets idx to 0.
  - result_valid stays 1 until reset.
- Only rising edges of start_display are acted on. The high level during sorter idle is ignored, and the X/unknown level before the sorter's first partD produces no capture.
- freeze=1 during the rising edge: no capture, and the edge is consumed (sd_q still updates). Lowering freeze later does not capture retroactively.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - At terminal count idx <= idx+1 mod 4, so idx 3 wraps to 0.
  - Runs whether or not result_valid is set.
- Digit mapping (reads ascending left to right):
  - idx0 -> an=4'b0111 shows held0.
  - idx1 -> an=4'b1011 shows held1.
  - idx2 -> an=4'b1101 shows held2.
  - idx3 -> an=4'b1110 shows held3.
- Outputs registered: an and seg reflect idx/held from the previous cycle (1-cycle latency).
  - Capture at edge N gives the new digit0 value on seg after edge N+1.
- result_valid=0 forces an=4'b1111 and seg=7'h7F (blank).
- Hex decode, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Capture on the same edge as a refresh terminal count: the capture clear wins (counter=0, idx=0).

Decomposition:
- Shared package holds:
  - the 16-entry SEG_LUT constant;
  - SEG_BLANK=7'h7F and AN_OFF=4'hF;
  - the digit-to-anode mapping.
- Sub-module hex7seg: pure combinational 4-bit to 7-bit active-low decoder using SEG_LUT.
- Top module owns the edge detect, the holding registers, the refresh counter, idx and the output registers.

Test Plan (REFRESH_DIV=4):
- Reset, start_display held 1, no edge -> result_valid=0, an=F, seg=7F indefinitely.
- Drive sorted={1,3,9,C}, start_display 1->0->0->1 -> result_valid=1 on the capture edge. Next cycle an=7, seg=79. After 4 cycles an=B, seg=30; then an=D, seg=10; then an=E, seg=46; then it wraps to an=7.
- freeze=1 across a done edge with new values {0,0,0,0} -> display keeps 1,3,9,C. Dropping freeze alone causes no change.
- Second done edge mid-scan while idx=2 -> counter/idx restart at 0. New digit0 appears 1 cycle later and the old values never reappear.
- Assert rst while idx=3 with a result held -> an=F, seg=7F, result_valid=0 asynchronously, before the next clk edge.
- Capture coinciding with refresh terminal count -> idx=0, counter=0. The next digit change occurs exactly 4 cycles later.
